// File: rtl/mem_move_core.sv
// Load/store micro-sequencer: executes one instruction at a time against a small register file.
// Optional MEM_TIMEOUT_EN build adds a mem_ack watchdog that halts with error code 4.
module mem_move_core #(
    parameter int unsigned WORDWIDTH = 16,
    parameter int unsigned ADDRWIDTH = 16,
    parameter int unsigned REGNUM    = 4,
    parameter int unsigned REGIDXW   = 2,
    parameter int unsigned FIELDW    = 16,
    parameter int unsigned MEMDEPTH  = 65536,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3+REGIDXW+FIELDW-1:0] instr,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    output logic                        instr_done,
    output logic [WORDWIDTH-1:0]        data_out,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDRWIDTH-1:0]        mem_addr,
    output logic [WORDWIDTH-1:0]        mem_wdata,
    input  logic                        mem_ack,
    input  logic [WORDWIDTH-1:0]        mem_rdata,
    output logic [2:0]                  err_code
);
    localparam int unsigned IW = 3 + REGIDXW + FIELDW;

    localparam logic [2:0] OP_LD  = 3'd0;
    localparam logic [2:0] OP_ST  = 3'd1;
    localparam logic [2:0] OP_LI  = 3'd2;
    localparam logic [2:0] OP_SI  = 3'd3;
    localparam logic [2:0] OP_MV  = 3'd4;
    localparam logic [2:0] OP_OUT = 3'd5;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_OP    = 3'd1;
    localparam logic [2:0] ERR_ADDR  = 3'd2;
    localparam logic [2:0] ERR_REG   = 3'd3;
    localparam logic [2:0] ERR_TOUT  = 3'd4;

    if (REGNUM < 2 || REGNUM > 16 || (1 << REGIDXW) < REGNUM ||
        FIELDW < WORDWIDTH || FIELDW < ADDRWIDTH || TIMEOUT < 1) begin : g_bad_params
        $error("mem_move_core: inconsistent parameters");
    end

    typedef enum logic [1:0] {IDLE, MEM, HALT} state_t;

    state_t                 state, state_n;
    logic                   ready_q, ready_n;
    logic                   done_q, done_n;
    logic [WORDWIDTH-1:0]   dout_q, dout_n;
    logic                   req_q, req_n;
    logic                   we_q, we_n;
    logic [ADDRWIDTH-1:0]   addr_q, addr_n;
    logic [WORDWIDTH-1:0]   wdata_q, wdata_n;
    logic [2:0]             err_q, err_n;
    logic                   pend_ld, pend_ld_n;
    logic [REGIDXW-1:0]     pend_dst, pend_dst_n;

    logic [WORDWIDTH-1:0]   regs [REGNUM];
    logic                   rf_we;
    logic [REGIDXW-1:0]     rf_idx;
    logic [WORDWIDTH-1:0]   rf_wdata;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0]        cnt, cnt_n;
`endif

    logic [2:0]             op;
    logic [REGIDXW-1:0]     dst;
    logic [FIELDW-1:0]      src;
    logic [REGIDXW-1:0]     src_idx;
    logic [WORDWIDTH-1:0]   dst_val;
    logic [WORDWIDTH-1:0]   src_val;
    logic                   is_mem;
    logic [ADDRWIDTH-1:0]   addr_sel;
    logic [2:0]             chk_err;

    assign op      = instr[IW-1 -: 3];
    assign dst     = instr[FIELDW +: REGIDXW];
    assign src     = instr[FIELDW-1:0];
    assign src_idx = src[REGIDXW-1:0];
    assign dst_val = regs[dst];
    assign src_val = regs[src_idx];
    assign is_mem  = (op == OP_LD) || (op == OP_ST) || (op == OP_SI);
    assign addr_sel = (op == OP_SI) ? ADDRWIDTH'(dst_val) : ADDRWIDTH'(src);

    // Accept-time fault checks, first match wins
    always_comb begin
        chk_err = ERR_NONE;
        if (op > OP_OUT) begin
            chk_err = ERR_OP;
        end else if (32'(dst) >= REGNUM || (op == OP_MV && 32'(src_idx) >= REGNUM)) begin
            chk_err = ERR_REG;
        end else if (is_mem && 32'(addr_sel) >= MEMDEPTH) begin
            chk_err = ERR_ADDR;
        end
    end

    always_comb begin
        state_n    = state;
        ready_n    = ready_q;
        done_n     = 1'b0;
        dout_n     = dout_q;
        req_n      = req_q;
        we_n       = we_q;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        err_n      = err_q;
        pend_ld_n  = pend_ld;
        pend_dst_n = pend_dst;
        rf_we      = 1'b0;
        rf_idx     = dst;
        rf_wdata   = '0;
`ifdef MEM_TIMEOUT_EN
        cnt_n      = cnt;
`endif
        case (state)
            IDLE: begin
                if (instr_valid && ready_q) begin
                    if (chk_err != ERR_NONE) begin
                        err_n   = chk_err;
                        ready_n = 1'b0;
                        state_n = HALT;
                    end else begin
                        case (op)
                            OP_LI: begin
                                rf_we    = 1'b1;
                                rf_wdata = WORDWIDTH'(src);
                                done_n   = 1'b1;
                            end
                            OP_MV: begin
                                rf_we    = 1'b1;
                                rf_wdata = src_val;
                                done_n   = 1'b1;
                            end
                            OP_OUT: begin
                                dout_n = dst_val;
                                done_n = 1'b1;
                            end
                            default: begin
                                req_n      = 1'b1;
                                we_n       = (op != OP_LD);
                                addr_n     = addr_sel;
                                wdata_n    = (op == OP_SI) ? WORDWIDTH'(src) : dst_val;
                                pend_ld_n  = (op == OP_LD);
                                pend_dst_n = dst;
                                ready_n    = 1'b0;
                                state_n    = MEM;
`ifdef MEM_TIMEOUT_EN
                                cnt_n      = '0;
`endif
                            end
                        endcase
                    end
                end
            end
            MEM: begin
                if (mem_ack) begin
                    req_n   = 1'b0;
                    ready_n = 1'b1;
                    done_n  = 1'b1;
                    state_n = IDLE;
                    if (pend_ld) begin
                        rf_we    = 1'b1;
                        rf_idx   = pend_dst;
                        rf_wdata = mem_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (cnt == CNTW'(TIMEOUT - 1)) begin
                    req_n   = 1'b0;
                    err_n   = ERR_TOUT;
                    state_n = HALT;
                end else begin
                    cnt_n = cnt + CNTW'(1);
`endif
                end
            end
            HALT: begin
                ready_n = 1'b0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            dout_q   <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= ERR_NONE;
            pend_ld  <= 1'b0;
            pend_dst <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt      <= '0;
`endif
        end else begin
            state    <= state_n;
            ready_q  <= ready_n;
            done_q   <= done_n;
            dout_q   <= dout_n;
            req_q    <= req_n;
            we_q     <= we_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            err_q    <= err_n;
            pend_ld  <= pend_ld_n;
            pend_dst <= pend_dst_n;
`ifdef MEM_TIMEOUT_EN
            cnt      <= cnt_n;
`endif
        end
    end

    // Register file; writes come only from the FSM decode above
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(REGNUM); i++) begin
                regs[i] <= '0;
            end
        end else if (rf_we) begin
            regs[rf_idx] <= rf_wdata;
        end
    end

    assign instr_ready = ready_q;
    assign instr_done  = done_q;
    assign data_out    = dout_q;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign err_code    = err_q;

endmodule

// File: tb/tb_mem_move_core.sv
// Scoreboard bench for mem_move_core: random instruction stream checked against a behavioural model.
module tb_mem_move_core;
    localparam int unsigned WW  = 16;
    localparam int unsigned AW  = 16;
    localparam int unsigned RN  = 3;
    localparam int unsigned RIW = 2;
    localparam int unsigned FW  = 16;
    localparam int unsigned MD  = 256;
    localparam int unsigned TO  = 8;
    localparam int unsigned IW  = 3 + RIW + FW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [IW-1:0] instr = '0;
    logic          instr_valid = 1'b0;
    logic          instr_ready, instr_done;
    logic [WW-1:0] data_out;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [WW-1:0] mem_rdata = '0;
    logic [2:0]    err_code;

    mem_move_core #(
        .WORDWIDTH(WW), .ADDRWIDTH(AW), .REGNUM(RN), .REGIDXW(RIW),
        .FIELDW(FW), .MEMDEPTH(MD), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_done(instr_done), .data_out(data_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [WW-1:0] wdata;
    } mreq_t;

    mreq_t         mq[$];
    logic [WW-1:0] dq[$];
    logic [WW-1:0] mref [logic [AW-1:0]];
    logic [WW-1:0] dev  [logic [AW-1:0]];
    logic [WW-1:0] rm [RN];
    logic [WW-1:0] dout_m = '0;
    int            tests = 0;
    int            fails = 0;
    bit            mute = 1'b0;
    bit            stray = 1'b0;
    int            fixed_lat = -1;

    function automatic logic [WW-1:0] init_val(input logic [AW-1:0] a);
        return WW'(a) ^ 16'hA5C3;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory responder with random (or forced) ack latency
    int wl = -1;
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (stray) begin
            mem_ack   = 1'b1;
            mem_rdata = 16'hDEAD;
            stray     = 1'b0;
            wl        = -1;
        end else if (mem_req && !mute && !reset) begin
            if (wl < 0) wl = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
            if (wl == 0) begin
                mem_ack = 1'b1;
                if (mem_we) dev[mem_addr] = mem_wdata;
                else mem_rdata = dev.exists(mem_addr) ? dev[mem_addr] : init_val(mem_addr);
                wl = -1;
            end else begin
                wl--;
            end
        end else begin
            wl = -1;
        end
    end

    // Monitor: retire pulses and memory requests against the scoreboard queues
    bit    in_req = 1'b0;
    mreq_t cur;
    always @(negedge clk) begin
        if (reset) begin
            in_req = 1'b0;
        end else begin
            if (instr_done) begin
                if (dq.size() == 0) check("stray_done", 32'(instr_done), 32'(0));
                else check("data_out_at_done", 32'(data_out), 32'(dq.pop_front()));
            end
            if (mem_req) begin
                check("ready_low_in_mem", 32'(instr_ready), 32'(0));
                if (!in_req) begin
                    if (mq.size() == 0) begin
                        check("stray_req", 32'(mem_req), 32'(0));
                    end else begin
                        cur = mq.pop_front();
                        check("req_we", 32'(mem_we), 32'(cur.we));
                        check("req_addr", 32'(mem_addr), 32'(cur.addr));
                        if (cur.we) check("req_wdata", 32'(mem_wdata), 32'(cur.wdata));
                    end
                end else begin
                    check("hold_we", 32'(mem_we), 32'(cur.we));
                    check("hold_addr", 32'(mem_addr), 32'(cur.addr));
                    if (cur.we) check("hold_wdata", 32'(mem_wdata), 32'(cur.wdata));
                end
            end
            in_req = mem_req;
        end
    end

    task automatic do_reset();
        instr_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'(0));
        @(negedge clk);
        check("rst_ready", 32'(instr_ready), 32'(1));
        check("rst_done", 32'(instr_done), 32'(0));
        check("rst_data_out", 32'(data_out), 32'(0));
        check("rst_we", 32'(mem_we), 32'(0));
        check("rst_addr", 32'(mem_addr), 32'(0));
        check("rst_wdata", 32'(mem_wdata), 32'(0));
        check("rst_err", 32'(err_code), 32'(0));
        for (int i = 0; i < int'(RN); i++) rm[i] = '0;
        dout_m = '0;
        dq.delete();
        mq.delete();
        reset = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [RIW-1:0] dst, input logic [FW-1:0] src);
        int            n = 0;
        logic [2:0]    e = 3'd0;
        logic [AW-1:0] a = '0;
        while (!instr_ready && n < 100) begin
            instr_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            check("ready_wait_expired", 32'(instr_ready), 32'(1));
            return;
        end
        instr = {op, dst, src};
        instr_valid = 1'b1;
        if (op > 3'd5) e = 3'd1;
        else if (32'(dst) >= RN || (op == 3'd4 && 32'(src[RIW-1:0]) >= RN)) e = 3'd3;
        else begin
            a = (op == 3'd3) ? AW'(rm[dst]) : src[AW-1:0];
            if ((op == 3'd0 || op == 3'd1 || op == 3'd3) && 32'(a) >= MD) e = 3'd2;
        end
        if (e == 3'd0) begin
            case (op)
                3'd0: begin
                    mq.push_back('{we: 1'b0, addr: a, wdata: '0});
                    rm[dst] = mref.exists(a) ? mref[a] : init_val(a);
                end
                3'd1: begin
                    mq.push_back('{we: 1'b1, addr: a, wdata: rm[dst]});
                    mref[a] = rm[dst];
                end
                3'd2: rm[dst] = src[WW-1:0];
                3'd3: begin
                    mq.push_back('{we: 1'b1, addr: a, wdata: src[WW-1:0]});
                    mref[a] = src[WW-1:0];
                end
                3'd4: rm[dst] = rm[src[RIW-1:0]];
                default: dout_m = rm[dst];
            endcase
            dq.push_back(dout_m);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        if (e != 3'd0) begin
            @(negedge clk);
            @(negedge clk);
            check("halt_err_code", 32'(err_code), 32'(e));
            check("halt_ready", 32'(instr_ready), 32'(0));
            check("halt_no_req", 32'(mem_req), 32'(0));
            do_reset();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!instr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(instr_ready), 32'(1));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]     op;
        logic [RIW-1:0] d;
        logic [FW-1:0]  s;
        int             n;

        do_reset();

        // Back-to-back register ops retire on consecutive cycles
        send(3'd2, 2'd1, 16'h1234);
        check("done_pulse_li", 32'(instr_done), 32'(1));
        send(3'd4, 2'd2, 16'h0001);
        check("done_pulse_mv", 32'(instr_done), 32'(1));
        send(3'd5, 2'd2, 16'h0000);
        check("done_pulse_out", 32'(instr_done), 32'(1));
        check("out_1234", 32'(data_out), 32'h1234);

        fixed_lat = 3;
        send(3'd1, 2'd1, 16'h0010);
        wait_idle();
        fixed_lat = -1;

        dev[16'h0030] = 16'hBEEF;
        mref[16'h0030] = 16'hBEEF;
        send(3'd0, 2'd2, 16'h0030);
        send(3'd5, 2'd2, 16'h0000);
        check("out_beef", 32'(data_out), 32'hBEEF);

        send(3'd2, 2'd0, 16'h0020);
        send(3'd3, 2'd0, 16'h00AA);
        wait_idle();

        send(3'd6, 2'd0, 16'h0000);
        send(3'd2, 2'd3, 16'h0005);
        send(3'd0, 2'd0, 16'h0100);
        send(3'd4, 2'd1, 16'h0003);

        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 99) < 3) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            d  = ($urandom_range(0, 99) < 4) ? 2'd3 : RIW'($urandom_range(0, RN - 1));
            case (op)
                3'd2: s = ($urandom_range(0, 1) == 0) ? FW'($urandom_range(0, 255)) : FW'($urandom);
                3'd4: s = ($urandom_range(0, 19) == 0) ? FW'(3) : FW'($urandom_range(0, RN - 1));
                default: s = ($urandom_range(0, 19) == 0) ? FW'($urandom) : FW'($urandom_range(0, 255));
            endcase
            send(op, d, s);
            if ($urandom_range(0, 3) == 0) begin
                instr_valid = 1'b0;
                @(negedge clk);
            end
        end
        wait_idle();

`ifdef MEM_TIMEOUT_EN
        // LD with no ack gives up after TIMEOUT cycles
        mute = 1'b1;
        mq.push_back('{we: 1'b0, addr: 16'h0044, wdata: '0});
        instr = {3'd0, 2'd1, 16'h0044};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        n = 0;
        while (mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout_req_cycles", 32'(n), 32'(TO));
        check("timeout_err", 32'(err_code), 32'(4));
        check("timeout_req_low", 32'(mem_req), 32'(0));
        check("timeout_ready", 32'(instr_ready), 32'(0));
        do_reset();
        mute = 1'b0;
`endif

        // Reset while a load is outstanding; a late ack must be ignored
        send(3'd2, 2'd1, 16'h5A5A);
        mute = 1'b1;
        send(3'd0, 2'd1, 16'h0044);
        @(negedge clk);
        @(negedge clk);
        check("ld_pending_req", 32'(mem_req), 32'(1));
        do_reset();
        stray = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("late_ack_req", 32'(mem_req), 32'(0));
        check("late_ack_ready", 32'(instr_ready), 32'(1));
        mute = 1'b0;
        send(3'd5, 2'd1, 16'h0000);
        check("ld_reg_after_reset", 32'(data_out), 32'(0));

        wait_idle();
        repeat (3) @(negedge clk);
        check("done_queue_empty", 32'(dq.size()), 32'(0));
        check("req_queue_empty", 32'(mq.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
